// File: rtl/bike_mac_pipe_pkg.sv
// Shared types for the BIKE multiply-add / accumulate pipeline.
package bike_mac_pipe_pkg;

   typedef enum logic {
      MAC_MULADD = 1'b0,
      MAC_ACC    = 1'b1
   } mac_mode_t;

   typedef struct packed {
      logic      vld;
      mac_mode_t mode;
      logic      first;
      logic      last;
   } mac_sb_t;

   localparam mac_sb_t SB_IDLE = '{
      vld:   1'b0,
      mode:  MAC_MULADD,
      first: 1'b0,
      last:  1'b0
   };

endpackage

// File: rtl/bike_mac_pipe_mul.sv
// Unsigned pipelined multiplier with one shared stage enable.
// Datapath registers carry no reset so they map onto DSP pipeline regs.
module bike_mul_pipe #(
   parameter int A_WIDTH  = 25,
   parameter int B_WIDTH  = 18,
   parameter int MUL_PIPE = 2
) (
   input  logic                       clk,
   input  logic                       en,
   input  logic [A_WIDTH-1:0]         a,
   input  logic [B_WIDTH-1:0]         b,
   output logic [A_WIDTH+B_WIDTH-1:0] prod
);

   localparam int PW = A_WIDTH + B_WIDTH;

   generate
      if (MUL_PIPE == 1) begin : g_one
         logic [PW-1:0] p_q;

         always_ff @(posedge clk) begin
            if (en) p_q <= PW'(a) * PW'(b);
         end

         assign prod = p_q;
      end else begin : g_multi
         logic [A_WIDTH-1:0] a_q;
         logic [B_WIDTH-1:0] b_q;
         logic [PW-1:0]      p_q [MUL_PIPE-1];

         // Input regs, multiply reg, then extra product delay stages.
         always_ff @(posedge clk) begin
            if (en) begin
               a_q    <= a;
               b_q    <= b;
               p_q[0] <= PW'(a_q) * PW'(b_q);
               for (int i = 1; i < MUL_PIPE - 1; i++) begin
                  p_q[i] <= p_q[i-1];
               end
            end
         end

         assign prod = p_q[MUL_PIPE-2];
      end
   endgenerate

endmodule

// File: rtl/bike_mac_pipe.sv
// Pipelined multiply-add / multiply-accumulate with valid/ready handshake
// and sticky overflow over accumulation frames.
module bike_mac_pipe
   import bike_mac_pipe_pkg::*;
#(
   parameter int A_WIDTH  = 25,
   parameter int B_WIDTH  = 18,
   parameter int P_WIDTH  = 48,
   parameter int MUL_PIPE = 2
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               din_valid,
   output logic               din_ready,
   input  mac_mode_t          din_mode,
   input  logic               din_first,
   input  logic               din_last,
   input  logic [A_WIDTH-1:0] din_a,
   input  logic [B_WIDTH-1:0] din_b,
   input  logic [P_WIDTH-1:0] din_c,
   output logic               dout_valid,
   input  logic               dout_ready,
   output logic [P_WIDTH-1:0] dout,
   output logic               dout_ovf
);

   localparam int PW = A_WIDTH + B_WIDTH;

   logic               adv;
   logic [PW-1:0]      prod;
   mac_sb_t            sb_q [MUL_PIPE];
   logic [P_WIDTH-1:0] c_q  [MUL_PIPE];
   mac_sb_t            sb_o;
   logic [P_WIDTH-1:0] c_o;
   logic [P_WIDTH-1:0] acc_q;
   logic               ovf_q;
   logic [P_WIDTH-1:0] base;
   logic [P_WIDTH:0]   sum;
   logic               ovf_nxt;

   assign adv       = !dout_valid || dout_ready;
   assign din_ready = adv;

   bike_mul_pipe #(
      .A_WIDTH  (A_WIDTH),
      .B_WIDTH  (B_WIDTH),
      .MUL_PIPE (MUL_PIPE)
   ) u_mul (
      .clk  (clk),
      .en   (adv),
      .a    (din_a),
      .b    (din_b),
      .prod (prod)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < MUL_PIPE; i++) begin
            sb_q[i] <= SB_IDLE;
         end
      end else if (adv) begin
         sb_q[0] <= '{
            vld:   din_valid,
            mode:  din_mode,
            first: din_first,
            last:  din_last
         };
         for (int i = 1; i < MUL_PIPE; i++) begin
            sb_q[i] <= sb_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         c_q[0] <= din_c;
         for (int i = 1; i < MUL_PIPE; i++) begin
            c_q[i] <= c_q[i-1];
         end
      end
   end

   assign sb_o = sb_q[MUL_PIPE-1];
   assign c_o  = c_q[MUL_PIPE-1];

   // One adder serves both modes; only the base operand differs.
   always_comb begin
      base = c_o;
      if (sb_o.mode == MAC_ACC && !sb_o.first) base = acc_q;
      sum     = {1'b0, base} + {1'b0, P_WIDTH'(prod)};
      ovf_nxt = sum[P_WIDTH] | (sb_o.first ? 1'b0 : ovf_q);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         acc_q      <= '0;
         ovf_q      <= 1'b0;
         dout       <= '0;
         dout_ovf   <= 1'b0;
         dout_valid <= 1'b0;
      end else if (adv) begin
         dout_valid <= 1'b0;
         if (sb_o.vld) begin
            if (sb_o.mode == MAC_MULADD) begin
               dout       <= sum[P_WIDTH-1:0];
               dout_ovf   <= sum[P_WIDTH];
               dout_valid <= 1'b1;
            end else begin
               acc_q <= sum[P_WIDTH-1:0];
               ovf_q <= ovf_nxt;
               if (sb_o.last) begin
                  dout       <= sum[P_WIDTH-1:0];
                  dout_ovf   <= ovf_nxt;
                  dout_valid <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_bike_mac_pipe.sv
// Bench for bike_mac_pipe: directed scenarios plus randomized traffic
// against an arithmetic reference model of the accumulate semantics.
module tb_bike_mac_pipe;
   import bike_mac_pipe_pkg::*;

   localparam int AW = 25;
   localparam int BW = 18;
   localparam int PW = 48;
   localparam int MP = 2;
   localparam longint unsigned PMASK = (64'd1 << PW) - 1;
   localparam longint unsigned AMAX  = (64'd1 << AW) - 1;
   localparam longint unsigned BMAX  = (64'd1 << BW) - 1;

   typedef logic [PW:0] res_t;

   logic          clk = 1'b0;
   logic          resetn;
   logic          din_valid;
   logic          din_ready;
   mac_mode_t     din_mode;
   logic          din_first;
   logic          din_last;
   logic [AW-1:0] din_a;
   logic [BW-1:0] din_b;
   logic [PW-1:0] din_c;
   logic          dout_valid;
   logic          dout_ready;
   logic [PW-1:0] dout;
   logic          dout_ovf;

   always #5 clk = ~clk;

   bike_mac_pipe #(
      .A_WIDTH  (AW),
      .B_WIDTH  (BW),
      .P_WIDTH  (PW),
      .MUL_PIPE (MP)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .din_mode   (din_mode),
      .din_first  (din_first),
      .din_last   (din_last),
      .din_a      (din_a),
      .din_b      (din_b),
      .din_c      (din_c),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout       (dout),
      .dout_ovf   (dout_ovf)
   );

   res_t            got[$];
   res_t            exp[$];
   longint unsigned m_acc;
   bit              m_ovf;
   int              n_chk;
   int              n_pass;
   int              stab_err;
   int              ready_err;
   bit              hold_prev;
   res_t            held;
   bit              accepted;
   int              bp_mode;
   int              cyc;

   // Reference: whole-beat arithmetic, results queued in acceptance order.
   function automatic void model(mac_mode_t m, bit f, bit l,
                                 longint unsigned a, longint unsigned b,
                                 longint unsigned c);
      longint unsigned full;
      if (m == MAC_MULADD) begin
         full = c + a * b;
         exp.push_back({full[PW], full[PW-1:0]});
      end else begin
         full  = (f ? c : m_acc) + a * b;
         m_acc = full & PMASK;
         m_ovf = (f ? 1'b0 : m_ovf) | full[PW];
         if (l) exp.push_back({m_ovf, m_acc[PW-1:0]});
      end
   endfunction

   task automatic step();
      cyc++;
      case (bp_mode)
         1: dout_ready = cyc[0];
         2: dout_ready = ($urandom_range(0, 3) != 0);
         default: dout_ready = 1'b1;
      endcase
      #1;
      accepted = 1'b0;
      if (!resetn) begin
         m_acc = 0;
         m_ovf = 1'b0;
         while (exp.size() > got.size()) void'(exp.pop_back());
         hold_prev = 1'b0;
      end else begin
         if (din_ready !== (!dout_valid || dout_ready)) ready_err++;
         if (hold_prev && (dout_valid !== 1'b1 || {dout_ovf, dout} !== held))
            stab_err++;
         hold_prev = dout_valid && !dout_ready;
         held      = {dout_ovf, dout};
         if (din_valid && din_ready) begin
            accepted = 1'b1;
            model(din_mode, din_first, din_last, 64'(din_a), 64'(din_b), 64'(din_c));
         end
         if (dout_valid && dout_ready) got.push_back({dout_ovf, dout});
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(mac_mode_t m, bit f, bit l,
                       longint unsigned a, longint unsigned b,
                       longint unsigned c);
      int k;
      din_valid = 1'b1;
      din_mode  = m;
      din_first = f;
      din_last  = l;
      din_a     = a[AW-1:0];
      din_b     = b[BW-1:0];
      din_c     = c[PW-1:0];
      for (k = 0; k < 200; k++) begin
         step();
         if (accepted) break;
      end
      if (!accepted) begin
         n_chk++;
         $display("FAIL send_timeout din_ready stuck at %b want 1", din_ready);
      end
      din_valid = 1'b0;
   endtask

   task automatic drain();
      din_valid = 1'b0;
      bp_mode   = 0;
      repeat (MP + 6) step();
   endtask

   task automatic clear();
      got.delete();
      exp.delete();
      stab_err  = 0;
      ready_err = 0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) step();
      n_chk++;
      if (dout_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", dout_valid);
      else n_pass++;
      n_chk++;
      if (dout !== '0) $display("FAIL reset_dout got %h want 0", dout);
      else n_pass++;
      n_chk++;
      if (dout_ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", dout_ovf);
      else n_pass++;
      resetn = 1'b1;
      step();
      n_chk++;
      if (din_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", din_ready);
      else n_pass++;
      clear();
   endtask

   task automatic test_muladd_latency();
      logic seen [4];
      clear();
      bp_mode   = 0;
      din_valid = 1'b1;
      din_mode  = MAC_MULADD;
      din_first = 1'b0;
      din_last  = 1'b0;
      din_a     = 25'd3;
      din_b     = 18'd5;
      din_c     = 48'd7;
      step();
      din_valid = 1'b0;
      seen[0] = dout_valid;
      step();
      seen[1] = dout_valid;
      step();
      seen[2] = dout_valid;
      n_chk++;
      if (dout !== 48'd22 || dout_ovf !== 1'b0)
         $display("FAIL muladd_value got %0d ovf %b want 22 ovf 0", dout, dout_ovf);
      else n_pass++;
      step();
      seen[3] = dout_valid;
      n_chk++;
      if ({seen[0], seen[1], seen[2], seen[3]} !== 4'b0010)
         $display("FAIL muladd_latency valid seq %b%b%b%b want 0010",
                  seen[0], seen[1], seen[2], seen[3]);
      else n_pass++;
      drain();
   endtask

   task automatic test_acc_frame();
      clear();
      send(MAC_ACC, 1'b1, 1'b0, 2, 3, 10);
      send(MAC_ACC, 1'b0, 1'b0, 4, 5, 999);
      drain();
      n_chk++;
      if (got.size() != 0) $display("FAIL acc_early got %0d results want 0", got.size());
      else n_pass++;
      send(MAC_ACC, 1'b0, 1'b1, 1, 1, 0);
      drain();
      n_chk++;
      if (got.size() != 1 || got[0] !== {1'b0, 48'd37})
         $display("FAIL acc_frame got n=%0d v=%h want n=1 v=37", got.size(),
                  got.size() > 0 ? got[0] : res_t'(0));
      else n_pass++;
   endtask

   task automatic test_back_pressure();
      clear();
      bp_mode = 1;
      for (int i = 0; i < 8; i++) begin
         send(MAC_MULADD, 1'b0, 1'b0, 64'($urandom) & AMAX,
              64'($urandom) & BMAX, {$urandom, $urandom} & PMASK);
      end
      bp_mode = 1;
      repeat (6) step();
      drain();
      n_chk++;
      if (got.size() != 8) $display("FAIL bp_count got %0d want 8", got.size());
      else n_pass++;
      for (int i = 0; i < got.size() && i < exp.size(); i++) begin
         n_chk++;
         if (got[i] !== exp[i]) $display("FAIL bp_data[%0d] got %h want %h", i, got[i], exp[i]);
         else n_pass++;
      end
      n_chk++;
      if (stab_err != 0) $display("FAIL bp_stable got %0d changes want 0", stab_err);
      else n_pass++;
      n_chk++;
      if (ready_err != 0) $display("FAIL bp_ready got %0d errors want 0", ready_err);
      else n_pass++;
   endtask

   task automatic test_overflow();
      clear();
      send(MAC_ACC, 1'b1, 1'b1, 1, 1, PMASK);
      send(MAC_ACC, 1'b1, 1'b1, 2, 3, 0);
      drain();
      n_chk++;
      if (got.size() != 2) $display("FAIL ovf_count got %0d want 2", got.size());
      else n_pass++;
      if (got.size() == 2) begin
         n_chk++;
         if (got[0] !== {1'b1, 48'd0}) $display("FAIL ovf_wrap got %h want 1_0", got[0]);
         else n_pass++;
         n_chk++;
         if (got[1] !== {1'b0, 48'd6}) $display("FAIL ovf_clear got %h want 0_6", got[1]);
         else n_pass++;
      end
   endtask

   task automatic test_interleave();
      clear();
      send(MAC_ACC, 1'b1, 1'b0, 2, 2, 0);
      send(MAC_MULADD, 1'b1, 1'b1, 9, 9, 1);
      send(MAC_ACC, 1'b0, 1'b1, 1, 1, 0);
      drain();
      n_chk++;
      if (got.size() != 2 || got[0] !== {1'b0, 48'd82} || got[1] !== {1'b0, 48'd5})
         $display("FAIL interleave got n=%0d %h %h want 82 5", got.size(),
                  got.size() > 0 ? got[0] : res_t'(0),
                  got.size() > 1 ? got[1] : res_t'(0));
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      clear();
      send(MAC_ACC, 1'b1, 1'b0, 4, 4, 100);
      send(MAC_ACC, 1'b0, 1'b0, 5, 5, 0);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      n_chk++;
      if (dout_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", dout_valid);
      else n_pass++;
      drain();
      n_chk++;
      if (got.size() != 0) $display("FAIL rstmid_leak got %0d results want 0", got.size());
      else n_pass++;
      send(MAC_ACC, 1'b0, 1'b1, 3, 3, 77);
      drain();
      n_chk++;
      if (got.size() != 1 || got[0] !== {1'b0, 48'd9})
         $display("FAIL rstmid_acc got n=%0d v=%h want 9", got.size(),
                  got.size() > 0 ? got[0] : res_t'(0));
      else n_pass++;
   endtask

   task automatic test_random();
      longint unsigned a, b, c;
      mac_mode_t m;
      clear();
      for (int i = 0; i < 400; i++) begin
         m = mac_mode_t'($urandom_range(0, 1));
         a = ($urandom_range(0, 3) == 0) ? AMAX : (64'($urandom) & AMAX);
         b = ($urandom_range(0, 3) == 0) ? BMAX : (64'($urandom) & BMAX);
         c = ($urandom_range(0, 3) == 0) ? PMASK - 64'($urandom_range(0, 50))
                                         : ({$urandom, $urandom} & PMASK);
         bp_mode = 2;
         send(m, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, a, b, c);
         if ($urandom_range(0, 3) == 0) step();
      end
      drain();
      n_chk++;
      if (got.size() != exp.size())
         $display("FAIL rand_count got %0d want %0d", got.size(), exp.size());
      else n_pass++;
      for (int i = 0; i < got.size() && i < exp.size(); i++) begin
         n_chk++;
         if (got[i] !== exp[i]) $display("FAIL rand_data[%0d] got %h want %h", i, got[i], exp[i]);
         else n_pass++;
      end
      n_chk++;
      if (stab_err != 0) $display("FAIL rand_stable got %0d changes want 0", stab_err);
      else n_pass++;
      n_chk++;
      if (ready_err != 0) $display("FAIL rand_ready got %0d errors want 0", ready_err);
      else n_pass++;
   endtask

   initial begin
      n_chk      = 0;
      n_pass     = 0;
      cyc        = 0;
      bp_mode    = 0;
      hold_prev  = 1'b0;
      m_acc      = 0;
      m_ovf      = 1'b0;
      resetn     = 1'b0;
      din_valid  = 1'b0;
      din_mode   = MAC_MULADD;
      din_first  = 1'b0;
      din_last   = 1'b0;
      din_a      = '0;
      din_b      = '0;
      din_c      = '0;
      dout_ready = 1'b1;
      test_reset();
      test_muladd_latency();
      test_acc_frame();
      test_back_pressure();
      test_overflow();
      test_interleave();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
